hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the rv32 in-order pipeline.
- Holds a scoreboard of in-flight destination registers for stages EXE..WB. Per decoded instruction it produces forwarding selects, load-use stalls, and branch-redirect flushes.
- Sits beside decode_ctl/execute_ctl. Drives the IF/DE hold, EXE bubble insertion and the operand-mux selects.
- Generalised in pipeline depth and load latency. Adds saturating performance counters.

---
 rtl/rv32_pipe_pkg.sv | 20 ++
 rtl/hazard_fwd_match.sv | 34 +++
 rtl/hazard_unit.sv | 96 +++++++++
 tb/tb_hazard_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - shared pipeline stage indices, forwarding codes and scoreboard entry type
package rv32_pipe_pkg;

  localparam int STG_EXE = 0;
  localparam int STG_ACC = 1;
  localparam int STG_WB  = 2;

  localparam int FWD_RF  = 0;

  // Widest register address a scoreboard entry can hold; narrower RA_W is zero-extended.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wen;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// rtl/hazard_fwd_match.sv - priority matcher of one source operand against the in-flight scoreboard
module hazard_fwd_match
  import rv32_pipe_pkg::*;
#(
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int RA_W     = 5,
  localparam int KW       = $clog2(DEPTH)
) (
  input  sb_entry_t        sb [DEPTH],
  input  logic             de_valid,
  input  logic             use_rs,
  input  logic [RA_W-1:0]  rs,
  output logic             hit,
  output logic [KW-1:0]    k,
  output logic             available
);

  // Scan oldest to youngest so the youngest producer overwrites any older match.
  always_comb begin
    hit       = 1'b0;
    k         = '0;
    available = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (de_valid && use_rs && (rs != '0) && sb[i].valid && sb[i].wen &&
          (sb[i].rd == SB_RD_W'(rs))) begin
        hit       = 1'b1;
        k         = KW'(i);
        available = !sb[i].is_load || (i >= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, redirect flush and operand forwarding control for the rv32 pipeline
module hazard_unit
  import rv32_pipe_pkg::*;
#(
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int RA_W     = 5,
  parameter  int CNT_W    = 32,
  localparam int KW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_valid,
  input  logic [RA_W-1:0]  de_rs1,
  input  logic [RA_W-1:0]  de_rs2,
  input  logic             de_use_rs1,
  input  logic             de_use_rs2,
  input  logic [RA_W-1:0]  de_rd,
  input  logic             de_wen,
  input  logic             de_is_load,
  input  logic             exe_redirect,
  output logic             stall_de,
  output logic             flush_de,
  output logic             exe_valid,
  output logic [KW-1:0]    fwd_a_sel,
  output logic [KW-1:0]    fwd_b_sel,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  sb_entry_t       sb [DEPTH];
  sb_entry_t       de_entry;
  logic            hit_a, hit_b, av_a, av_b;
  logic [KW-1:0]   k_a, k_b;
  logic            load_de;

  hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W)) u_match_a (
    .sb        (sb),
    .de_valid  (de_valid),
    .use_rs    (de_use_rs1),
    .rs        (de_rs1),
    .hit       (hit_a),
    .k         (k_a),
    .available (av_a)
  );

  hazard_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .RA_W(RA_W)) u_match_b (
    .sb        (sb),
    .de_valid  (de_valid),
    .use_rs    (de_use_rs2),
    .rs        (de_rs2),
    .hit       (hit_b),
    .k         (k_b),
    .available (av_b)
  );

  // A producer already in the last stage has written the write-first register file.
  function automatic logic [KW-1:0] fwd_code(input logic h, input logic av, input logic [KW-1:0] k);
    if (h && av && (int'(k) < DEPTH - 1))
      return k + KW'(1);
    return KW'(FWD_RF);
  endfunction

  assign flush_de = exe_redirect;
  assign stall_de = !exe_redirect && ((hit_a && !av_a) || (hit_b && !av_b));
  assign load_de  = de_valid && !stall_de && !exe_redirect;

  assign de_entry.valid   = 1'b1;
  assign de_entry.rd      = SB_RD_W'(de_rd);
  assign de_entry.wen     = de_wen;
  assign de_entry.is_load = de_is_load;

  assign exe_valid = sb[STG_EXE].valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        sb[i] <= '0;
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      sb[STG_EXE] <= load_de ? de_entry : '0;
      for (int i = 1; i < DEPTH; i++)
        sb[i] <= sb[i-1];
      fwd_a_sel <= load_de ? fwd_code(hit_a, av_a, k_a) : KW'(FWD_RF);
      fwd_b_sel <= load_de ? fwd_code(hit_b, av_b, k_b) : KW'(FWD_RF);
      if (stall_de && !(&cnt_stall))
        cnt_stall <= cnt_stall + CNT_W'(1);
      if (flush_de && !(&cnt_flush))
        cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with DEPTH=3, LOAD_LAT=1, 4-bit counters
module tb_hazard_unit;

  localparam int DEPTH = 3;
  localparam int KW    = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             de_valid, de_use_rs1, de_use_rs2, de_wen, de_is_load, exe_redirect;
  logic [4:0]       de_rs1, de_rs2, de_rd;
  logic             stall_de, flush_de, exe_valid;
  logic [KW-1:0]    fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { int fa; int fb; } exp_t;
  exp_t exp_q[$];

  hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(1), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .de_valid     (de_valid),
    .de_rs1       (de_rs1),
    .de_rs2       (de_rs2),
    .de_use_rs1   (de_use_rs1),
    .de_use_rs2   (de_use_rs2),
    .de_rd        (de_rd),
    .de_wen       (de_wen),
    .de_is_load   (de_is_load),
    .exe_redirect (exe_redirect),
    .stall_de     (stall_de),
    .flush_de     (flush_de),
    .exe_valid    (exe_valid),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .cnt_stall    (cnt_stall),
    .cnt_flush    (cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every real instruction seen in EXE must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && exe_valid) begin
      if (exp_q.size() == 0) begin
        chk("exe_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fwd_a_sel", int'(fwd_a_sel), e.fa);
        chk("fwd_b_sel", int'(fwd_b_sel), e.fb);
      end
    end
  end

  // One decode cycle: drive, check combinational stall/flush, queue expected EXE view.
  task automatic row(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wen, input bit ld, input bit redir,
                     input bit es, input bit ef, input int fa, input int fb);
    de_valid = v; de_rs1 = 5'(rs1); de_use_rs1 = u1; de_rs2 = 5'(rs2); de_use_rs2 = u2;
    de_rd = 5'(rd); de_wen = wen; de_is_load = ld; exe_redirect = redir;
    @(negedge clk);
    chk("stall_de", int'(stall_de), int'(es));
    chk("flush_de", int'(flush_de), int'(ef));
    if (v && !es && !ef) exp_q.push_back('{fa, fb});
    @(posedge clk); #1;
    chk("exe_valid", int'(exe_valid), int'(v && !es && !ef));
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
    de_rd = 0; de_wen = 0; de_is_load = 0; exe_redirect = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", int'(stall_de), 0);
    chk("rst_exe_valid", int'(exe_valid), 0);
    chk("rst_fwd_a", int'(fwd_a_sel), 0);
    chk("rst_fwd_b", int'(fwd_b_sel), 0);
    chk("rst_cnt_stall", int'(cnt_stall), 0);
    chk("rst_cnt_flush", int'(cnt_flush), 0);
    @(posedge clk); #1 rst = 1'b1;

    // addi x5 ; add x6,x5,x7 -> forward from EXE result
    row(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    row(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0, 1, 0);
    nops(3);

    // producer, one gap, consumer via rs2 -> stage 2; two gaps -> register file
    row(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 2);
    nops(3);
    row(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    nops(3);

    // lw x5 ; add x6,x5,x0 -> one stall cycle then forward from stage 2
    row(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    row(1, 5, 1, 0, 1, 6, 1, 0, 0, 1, 0, 0, 0);
    row(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 2, 0);
    chk("cnt_stall_after_lu", int'(cnt_stall), 1);
    nops(3);

    // x0 never matches, even as a load destination
    row(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    row(1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    nops(3);

    // load-use coincident with redirect: flush wins, no stall counted
    row(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    row(1, 5, 1, 0, 1, 6, 1, 0, 1, 0, 1, 0, 0);
    chk("cnt_flush_after_redir", int'(cnt_flush), 1);
    chk("cnt_stall_after_redir", int'(cnt_stall), 1);
    nops(3);

    // reset asserted during a stall cycle clears outputs without a clock edge
    row(1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    row(1, 7, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0);
    de_valid = 1; de_rs1 = 5; de_use_rs1 = 1; de_rs2 = 0; de_use_rs2 = 0;
    de_rd = 6; de_wen = 1; de_is_load = 0; exe_redirect = 0;
    @(negedge clk);
    chk("pre_rst_stall", int'(stall_de), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_stall", int'(stall_de), 0);
    chk("mid_rst_exe_valid", int'(exe_valid), 0);
    chk("mid_rst_fwd_a", int'(fwd_a_sel), 0);
    chk("mid_rst_fwd_b", int'(fwd_b_sel), 0);
    chk("mid_rst_cnt_stall", int'(cnt_stall), 0);
    chk("mid_rst_cnt_flush", int'(cnt_flush), 0);
    @(posedge clk); #1 rst = 1'b1;
    row(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    nops(3);

    // 17 stall events into a 4-bit counter saturate at 15
    for (int i = 0; i < 17; i++) begin
      row(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
      row(1, 0, 0, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0);
      row(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 0, 2);
      if (i == 13) chk("cnt_stall_14", int'(cnt_stall), 14);
    end
    chk("cnt_stall_sat", int'(cnt_stall), 15);
    for (int i = 0; i < 17; i++) row(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("cnt_flush_sat", int'(cnt_flush), 15);
    nops(2);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
